// File: rtl/fpu_norm_pack.sv
// Normalise a raw FP significand, round to nearest-even and pack as binary32.
// One shift per cycle in NORM; ROUND packs the result and applies ovf/unf.
module fpu_norm_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [47:0]        mant_q, mant_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        out_q, out_d;
  logic [3:0]         flags_q, flags_d;

  logic               g_bit;
  logic               s_bit;
  logic               rnd_up;
  logic [23:0]        frac_sum;
  logic               carry;
  logic signed [9:0]  exp_r;
  logic [22:0]        frac_r;

  // Round-to-nearest-even on the normalised significand (hidden bit at 46).
  always_comb begin
    g_bit    = mant_q[22];
    s_bit    = (|mant_q[21:0]) | sticky_q;
    rnd_up   = g_bit & (s_bit | mant_q[23]);
    frac_sum = {1'b0, mant_q[45:23]} + {23'b0, rnd_up};
    carry    = frac_sum[23];
    exp_r    = exp_q + $signed({9'b0, carry});
    frac_r   = frac_sum[22:0];
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      out_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
    end
  end

  // Next-state and datapath updates for each phase of an operation.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    out_d    = out_q;
    flags_d  = flags_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = in_exp;
          mant_d   = in_mant;
          sticky_d = 1'b0;
          if (in_mant == 48'h0) begin
            out_d   = {in_sign, 31'b0};
            flags_d = 4'b0001;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mant_q[47]) begin
          mant_d   = mant_q >> 1;
          exp_d    = exp_q + 10'sd1;
          sticky_d = sticky_q | mant_q[0];
          state_d  = ROUND;
        end else if (mant_q[46]) begin
          state_d = ROUND;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 10'sd1;
        end
      end
      ROUND: begin
        if (exp_r >= 10'sd255) begin
          out_d   = {sign_q, 8'hFF, 23'b0};
          flags_d = 4'b1010;
        end else if (exp_r <= 10'sd0) begin
          out_d   = {sign_q, 31'b0};
          flags_d = 4'b0111;
        end else begin
          out_d   = {sign_q, exp_r[7:0], frac_r};
          flags_d = {2'b00, g_bit | s_bit, 1'b0};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign flags     = flags_q;

endmodule
